// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin sequencer in front of a single-port RAM.
// One command is captured in IDLE, issued for one cycle, and reads return data in RESP.
module ram_access_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    ptr;
  logic                    sel, sel_nxt;
  logic                    take;
  logic                    we_win;
  logic [ADDR_W-1:0]       addr_win;
  logic [DATA_W-1:0]       wdata_win;
  logic [1:0]              gnt, rvalid;
  logic [1:0][DATA_W-1:0]  rdata_q;

  // Winner selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          state_nxt = ISSUE;
          sel_nxt   = (req0 && req1) ? ptr : req1;
        end
      end
      ISSUE:   state_nxt = ram_we ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign we_win    = sel_nxt ? we1    : we0;
  assign addr_win  = sel_nxt ? addr1  : addr0;
  assign wdata_win = sel_nxt ? wdata1 : wdata0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      sel       <= 1'b0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata_q   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      busy   <= (state_nxt != IDLE);
      gnt    <= '0;
      rvalid <= '0;
      ram_en <= take;
      ram_we <= take & we_win;
      if (take) begin
        gnt[sel_nxt] <= 1'b1;
        ram_addr     <= addr_win;
        ram_wdata    <= wdata_win;
      end
      if (state == ISSUE) begin
        ptr <= ~sel;
        if (!ram_we) rvalid[sel] <= 1'b1;
      end
      if (state == RESP) rdata_q[sel] <= ram_rdata;
    end
  end

  // RAM data is only valid during RESP, so it is forwarded then and held afterwards.
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rvalid[0] ? ram_rdata : rdata_q[0];
  assign rdata1  = rvalid[1] ? ram_rdata : rdata_q[1];

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed scenarios plus a randomized transaction-level scoreboard.
module tb_ram_access_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       gnt0, rvalid0, gnt1, rvalid1;
  logic [1:0] rdata0, rdata1;
  logic       ram_en, ram_we;
  logic [1:0] ram_addr, ram_wdata;
  logic [1:0] ram_rdata = '0;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [1:0] mem     [4];
  logic [1:0] ref_mem [4];
  logic       exp_ptr = 1'b0;
  logic       prev_en = 1'b0;

  ram_access_arbiter #(.ADDR_W(2), .DATA_W(2)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Structural invariants sampled every cycle.
  always @(negedge clock) begin
    checks++;
    if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
      errors++;
      $display("FAIL excl: gnt=%b%b rvalid=%b%b at cyc %0d", gnt1, gnt0, rvalid1, rvalid0, cyc);
    end
    checks++;
    if ((ram_en && prev_en) || (ram_we && !ram_en)) begin
      errors++;
      $display("FAIL ram_strobe: en=%b prev_en=%b we=%b at cyc %0d", ram_en, prev_en, ram_we, cyc);
    end
    prev_en = ram_en;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we, busy} !== 7'b0 ||
        {ram_addr, ram_wdata, rdata0, rdata1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b rv=%b%b en=%b we=%b busy=%b addr=%0d wd=%0d rd0=%0d rd1=%0d, want all 0",
               gnt1, gnt0, rvalid1, rvalid0, ram_en, ram_we, busy, ram_addr, ram_wdata, rdata0, rdata1);
    end
    reset = 1'b0;
    exp_ptr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_then_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 2'd3;
    @(negedge clock);
    checks++;
    if (!(gnt0 === 1'b1 && gnt1 === 1'b0 && ram_en === 1'b1 && ram_we === 1'b1 &&
          ram_addr === 2'd2 && ram_wdata === 2'd3)) begin
      errors++;
      $display("FAIL wr_issue: gnt=%b%b en=%b we=%b addr=%0d wd=%0d, want gnt0 en we addr=2 wd=3",
               gnt1, gnt0, ram_en, ram_we, ram_addr, ram_wdata);
    end
    req0 = 1'b0; ref_mem[2] = 2'd3; exp_ptr = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: busy=%b en=%b, want 0 0", busy, ram_en);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
    @(negedge clock);
    checks++;
    if (!(gnt1 === 1'b1 && gnt0 === 1'b0 && ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 2'd2)) begin
      errors++;
      $display("FAIL rd_issue: gnt=%b%b en=%b we=%b addr=%0d, want gnt1 read addr=2", gnt1, gnt0, ram_en, ram_we, ram_addr);
    end
    req1 = 1'b0; exp_ptr = 1'b0;
    @(negedge clock);
    checks++;
    if (!(rvalid1 === 1'b1 && rvalid0 === 1'b0 && rdata1 === ref_mem[2])) begin
      errors++;
      $display("FAIL rd_resp: rv=%b%b rdata1=%0d, want rv1 only, rdata1=%0d", rvalid1, rvalid0, rdata1, ref_mem[2]);
    end
    @(negedge clock);
    checks++;
    if (!(rvalid1 === 1'b0 && rdata1 === ref_mem[2] && busy === 1'b0)) begin
      errors++;
      $display("FAIL rd_hold: rv1=%b rdata1=%0d busy=%b, want 0 %0d 0", rvalid1, rdata1, busy, ref_mem[2]);
    end
  endtask

  task automatic test_alternate();
    int last = 0;
    logic w;
    logic found;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int t = 0; t < 6 && !found; t++) begin
        @(negedge clock);
        if (gnt0 || gnt1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL alt_timeout: no grant for access %0d", k);
        break;
      end
      w = exp_ptr;
      checks++;
      if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_order: access %0d gnt=%b%b, want requester %0d", k, gnt1, gnt0, w);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last != 3) begin
          errors++;
          $display("FAIL alt_spacing: access %0d spacing %0d, want 3", k, cyc - last);
        end
      end
      last = cyc;
      exp_ptr = ~w;
      if (k == 3) begin if (w) req1 = 1'b0; else req0 = 1'b0; end
      if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clock);
      checks++;
      if (w ? (rvalid1 !== 1'b1 || rdata1 !== ref_mem[1]) : (rvalid0 !== 1'b1 || rdata0 !== ref_mem[0])) begin
        errors++;
        $display("FAIL alt_data: access %0d rv=%b%b rd0=%0d rd1=%0d, want rv%0d data %0d",
                 k, rvalid1, rvalid0, rdata0, rdata1, w, w ? ref_mem[1] : ref_mem[0]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_lone_writer();
    int last = 0;
    logic found;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd0; wdata1 = 2'($urandom_range(0, 3));
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int t = 0; t < 4 && !found; t++) begin
        @(negedge clock);
        if (gnt0 || gnt1) found = 1'b1;
      end
      checks++;
      if (!found || gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_we !== 1'b1 ||
          ram_addr !== addr1 || ram_wdata !== wdata1) begin
        errors++;
        $display("FAIL lone_grant: write %0d found=%b gnt=%b%b we=%b addr=%0d wd=%0d, want gnt1 we addr=%0d wd=%0d",
                 k, found, gnt1, gnt0, ram_we, ram_addr, ram_wdata, addr1, wdata1);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last != 2) begin
          errors++;
          $display("FAIL lone_spacing: write %0d spacing %0d, want 2", k, cyc - last);
        end
      end
      last = cyc;
      ref_mem[addr1] = wdata1;
      exp_ptr = 1'b0;
      if (k == 2) req1 = 1'b0;
      else begin
        addr1  = 2'(k + 1);
        wdata1 = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lone_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] wd0, wd1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: gnt0=%b, want 1", gnt0);
    end
    reset = 1'b1; req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (!(rvalid0 === 1'b0 && busy === 1'b0 && ram_en === 1'b0 && rdata0 === 2'd0 && rdata1 === 2'd0)) begin
      errors++;
      $display("FAIL abort_state: rv0=%b busy=%b en=%b rd0=%0d rd1=%0d, want all 0", rvalid0, busy, ram_en, rdata0, rdata1);
    end
    reset = 1'b0; exp_ptr = 1'b0;
    wd0 = 2'($urandom_range(0, 3)); wd1 = 2'($urandom_range(0, 3));
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = wd0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = wd1;
    @(negedge clock);
    checks++;
    if (!(gnt0 === 1'b1 && gnt1 === 1'b0 && rvalid0 === 1'b0 && ram_addr === 2'd0 && ram_wdata === wd0)) begin
      errors++;
      $display("FAIL post_reset_prio: gnt=%b%b rv0=%b addr=%0d wd=%0d, want gnt0 addr=0 wd=%0d",
               gnt1, gnt0, rvalid0, ram_addr, ram_wdata, wd0);
    end
    req0 = 1'b0; ref_mem[0] = wd0; exp_ptr = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (!(gnt1 === 1'b1 && gnt0 === 1'b0 && ram_addr === 2'd3 && ram_wdata === wd1)) begin
      errors++;
      $display("FAIL post_reset_second: gnt=%b%b addr=%0d wd=%0d, want gnt1 addr=3 wd=%0d",
               gnt1, gnt0, ram_addr, ram_wdata, wd1);
    end
    req1 = 1'b0; ref_mem[3] = wd1; exp_ptr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_scoreboard();
    logic       w, w_we;
    logic [1:0] w_addr, w_wd;
    for (int n = 0; n < 60 || req0 || req1; n++) begin
      if (n < 60 && !req0 && $urandom_range(0, 2) != 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 2'($urandom_range(0, 3)); wdata0 = 2'($urandom_range(0, 3));
      end
      if (n < 60 && !req1 && $urandom_range(0, 2) != 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 2'($urandom_range(0, 3)); wdata1 = 2'($urandom_range(0, 3));
      end
      if (!req0 && !req1) begin
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || gnt0 || gnt1) begin
          errors++;
          $display("FAIL sb_idle: busy=%b gnt=%b%b, want 0 00", busy, gnt1, gnt0);
        end
        continue;
      end
      w      = (req0 && req1) ? exp_ptr : req1;
      w_we   = w ? we1 : we0;
      w_addr = w ? addr1 : addr0;
      w_wd   = w ? wdata1 : wdata0;
      @(negedge clock);
      checks++;
      if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01) || ram_en !== 1'b1 || ram_we !== w_we ||
          ram_addr !== w_addr || (w_we && ram_wdata !== w_wd)) begin
        errors++;
        $display("FAIL sb_issue: n=%0d gnt=%b%b en=%b we=%b addr=%0d wd=%0d, want req%0d we=%b addr=%0d wd=%0d",
                 n, gnt1, gnt0, ram_en, ram_we, ram_addr, ram_wdata, w, w_we, w_addr, w_wd);
      end
      exp_ptr = ~w;
      if (w) req1 = 1'b0; else req0 = 1'b0;
      if (w_we) begin
        ref_mem[w_addr] = w_wd;
      end else begin
        @(negedge clock);
        checks++;
        if ((w ? {rvalid1, rvalid0} !== 2'b10 : {rvalid1, rvalid0} !== 2'b01) ||
            (w ? rdata1 : rdata0) !== ref_mem[w_addr]) begin
          errors++;
          $display("FAIL sb_read: n=%0d rv=%b%b data=%0d, want rv%0d data=%0d",
                   n, rvalid1, rvalid0, w ? rdata1 : rdata0, w, ref_mem[w_addr]);
        end
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || ram_en !== 1'b0 || rvalid0 || rvalid1) begin
        errors++;
        $display("FAIL sb_end: n=%0d busy=%b en=%b rv=%b%b, want all 0", n, busy, ram_en, rvalid1, rvalid0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_then_read();
    test_alternate();
    test_lone_writer();
    test_reset_mid();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
